pc_branch_unit: RTL

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit_if.sv | 30 +++
 rtl/pc_branch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/pc_branch_unit_if.sv
// Bundle of the decode-side branch inputs and the fetch/ID outputs of
// pc_branch_unit. The master side is the decoder/pipeline, the slave side is
// the branch unit itself.
interface pc_branch_unit_if;
  logic        Stall;
  logic [2:0]  BranchJump;
  logic [4:0]  RegimmRt;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] SignExtImm;
  logic [25:0] JumpTarget;
  logic        Link;
  logic [31:0] PC;
  logic [31:0] IdPC;
  logic        IdValid;
  logic        Flush;
  logic        LinkWrite;
  logic [31:0] LinkAddr;
  logic [15:0] TakenCount;

  modport master (
    output Stall, BranchJump, RegimmRt, RsData, RtData, SignExtImm, JumpTarget, Link,
    input  PC, IdPC, IdValid, Flush, LinkWrite, LinkAddr, TakenCount
  );

  modport slave (
    input  Stall, BranchJump, RegimmRt, RsData, RtData, SignExtImm, JumpTarget, Link,
    output PC, IdPC, IdValid, Flush, LinkWrite, LinkAddr, TakenCount
  );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC register plus MIPS-style branch/jump resolution in
// ID. The taken decision is combinational so the redirect, the squash of the
// wrong-path fetch and the $31 link write all happen in the deciding cycle.
// Optional feature: define PC_BRANCH_DELAY_SLOT_EN to keep the instruction
// after a branch (delay slot) instead of squashing it.
module pc_branch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic            Clk,
  input logic            Rst_n,
  pc_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic        id_valid;
  logic        cond_met;
  logic        taken;
  logic        is_jump;
  logic [31:0] id_pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;

  assign id_valid      = (state_q == RUN);
  assign is_jump       = (bus.BranchJump == 3'b011);
  assign id_pc_plus4   = id_pc_q + 32'd4;
  assign branch_target = id_pc_plus4 + (bus.SignExtImm << 2);
  assign jump_target   = {id_pc_plus4[31:28], bus.JumpTarget, 2'b00};
  assign target        = is_jump ? jump_target : branch_target;
  assign taken         = id_valid && !bus.Stall && cond_met;

  // Branch condition for the class decoded in ID; signed tests use the sign bit.
  always_comb begin
    cond_met = 1'b0;
    case (bus.BranchJump)
      3'b001: cond_met = (bus.RsData == bus.RtData);
      3'b010: cond_met = (bus.RsData != bus.RtData);
      3'b011: cond_met = 1'b1;
      3'b100: begin
        if (bus.RegimmRt == 5'b00000)      cond_met = bus.RsData[31];
        else if (bus.RegimmRt == 5'b00001) cond_met = !bus.RsData[31];
        else                               cond_met = 1'b0;
      end
      3'b101: cond_met = !bus.RsData[31] && (bus.RsData != 32'd0);
      3'b110: cond_met = bus.RsData[31] || (bus.RsData == 32'd0);
      default: cond_met = 1'b0;
    endcase
  end

  // Next PC, ID address, taken counter and sequencing state; a stall holds everything.
  always_comb begin
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    taken_count_d = taken_count_q;
    state_d       = state_q;
    if (!bus.Stall) begin
      id_pc_d = pc_q;
      pc_d    = taken ? target : pc_q + 32'd4;
      if (taken) taken_count_d = taken_count_q + 16'd1;
      case (state_q)
        BOOT:     state_d = RUN;
`ifdef PC_BRANCH_DELAY_SLOT_EN
        // The delay-slot instruction is architecturally executed, so no bubble.
        RUN:      state_d = RUN;
`else
        RUN:      state_d = taken ? REDIRECT : RUN;
`endif
        REDIRECT: state_d = RUN;
        default:  state_d = BOOT;
      endcase
    end
  end

  // State registers with asynchronous reset back to the reset vector.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      id_pc_q       <= RESET_VECTOR;
      taken_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.IdPC       = id_pc_q;
  assign bus.IdValid    = id_valid;
  assign bus.TakenCount = taken_count_q;
  assign bus.LinkWrite  = taken && is_jump && bus.Link;
`ifdef PC_BRANCH_DELAY_SLOT_EN
  assign bus.Flush      = 1'b0;
  assign bus.LinkAddr   = id_pc_q + 32'd8;
`else
  assign bus.Flush      = taken;
  assign bus.LinkAddr   = id_pc_q + 32'd4;
`endif

endmodule
